sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arb_pkg.sv | 49 ++++
 rtl/sdram_arb_port.sv | 58 +++++
 rtl/sdram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types for the three-port SDRAM arbiter: FSM states, latched request record
// and the round-robin grant helper.
package sdram_arb_pkg;

    localparam int N_PORTS = 3;
    localparam int AW      = 25;
    localparam int DW      = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        GUARD = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } arb_state_t;

    // op: 1 = write, 0 = read
    typedef struct packed {
        logic          op;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [1:0]    wtbt;
    } arb_req_t;

    // First pending port after 'last'; with prio0 a pending port 0 wins outright
    // and is otherwise skipped by the rotation.
    function automatic logic [1:0] rr_pick(input logic [N_PORTS-1:0] pend,
                                           input logic [1:0]         last,
                                           input logic               prio0);
        logic [1:0] pick;
        logic       found;
        int         cand;
        pick  = last;
        found = 1'b0;
        if (prio0 && pend[0]) begin
            pick  = 2'd0;
            found = 1'b1;
        end
        for (int i = 1; i <= N_PORTS; i++) begin
            cand = (int'(last) + i) % N_PORTS;
            if (!found && pend[cand] && !(prio0 && cand == 0)) begin
                pick  = 2'(cand);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sdram_arb_port.sv
// One client port: edge-detects rd/we, latches the request and owns ready/dout.
// Capture takes one cycle; edges arriving while busy are dropped, not queued.
module sdram_arb_port
    import sdram_arb_pkg::*;
(
    input  logic          clk,
    input  logic          init,
    input  logic          rd,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    input  logic [1:0]    wtbt,
    input  logic          done,
    input  logic          load,
    input  logic [DW-1:0] rdata,
    output arb_req_t      req,
    output logic          pending,
    output logic          ready,
    output logic [DW-1:0] dout
);

    logic rd_q;
    logic we_q;
    logic busy;
    logic rd_rise;
    logic we_rise;

    assign rd_rise = rd & ~rd_q;
    assign we_rise = we & ~we_q;

    // Edge history tracks the inputs even in init, so a held level is not an edge.
    always_ff @(posedge clk) begin
        rd_q <= rd;
        we_q <= we;
        if (init) begin
            busy <= 1'b0;
            req  <= '0;
            dout <= '0;
        end else begin
            if (!busy && (we_rise || rd_rise)) begin
                busy     <= 1'b1;
                req.op   <= we_rise;
                req.addr <= addr;
                req.din  <= din;
                req.wtbt <= wtbt;
            end else if (done) begin
                busy <= 1'b0;
            end
            if (load) begin
                dout <= rdata;
            end
        end
    end

    assign pending = busy;
    assign ready   = ~busy;

endmodule

// File: rtl/sdram_arbiter.sv
// Three-port arbiter in front of a single-request SDRAM controller; request-to-ready
// is 5 cycles minimum, ports stay not-ready (backpressured) until their access completes.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter bit PRIO0 = 1'b1
) (
    input  logic          clk,
    input  logic          init,
    input  logic          p0_rd,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_din,
    input  logic [1:0]    p0_wtbt,
    output logic [DW-1:0] p0_dout,
    output logic          p0_ready,
    input  logic          p1_rd,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_din,
    input  logic [1:0]    p1_wtbt,
    output logic [DW-1:0] p1_dout,
    output logic          p1_ready,
    input  logic          p2_rd,
    input  logic          p2_we,
    input  logic [AW-1:0] p2_addr,
    input  logic [DW-1:0] p2_din,
    input  logic [1:0]    p2_wtbt,
    output logic [DW-1:0] p2_dout,
    output logic          p2_ready,
    output logic [AW-1:0] sd_addr,
    output logic [DW-1:0] sd_din,
    output logic [1:0]    sd_wtbt,
    output logic          sd_rd,
    output logic          sd_we,
    input  logic [DW-1:0] sd_dout,
    input  logic          sd_ready
);

    logic [N_PORTS-1:0] rd_v;
    logic [N_PORTS-1:0] we_v;
    logic [N_PORTS-1:0] pending;
    logic [N_PORTS-1:0] ready_v;
    logic [N_PORTS-1:0] done_v;
    logic [N_PORTS-1:0] load_v;
    logic [AW-1:0]      addr_v [N_PORTS];
    logic [DW-1:0]      din_v  [N_PORTS];
    logic [DW-1:0]      dout_v [N_PORTS];
    logic [1:0]         wtbt_v [N_PORTS];
    arb_req_t           req_v  [N_PORTS];

    assign rd_v      = {p2_rd, p1_rd, p0_rd};
    assign we_v      = {p2_we, p1_we, p0_we};
    assign addr_v[0] = p0_addr;
    assign addr_v[1] = p1_addr;
    assign addr_v[2] = p2_addr;
    assign din_v[0]  = p0_din;
    assign din_v[1]  = p1_din;
    assign din_v[2]  = p2_din;
    assign wtbt_v[0] = p0_wtbt;
    assign wtbt_v[1] = p1_wtbt;
    assign wtbt_v[2] = p2_wtbt;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        sdram_arb_port u_port (
            .clk     (clk),
            .init    (init),
            .rd      (rd_v[i]),
            .we      (we_v[i]),
            .addr    (addr_v[i]),
            .din     (din_v[i]),
            .wtbt    (wtbt_v[i]),
            .done    (done_v[i]),
            .load    (load_v[i]),
            .rdata   (sd_dout),
            .req     (req_v[i]),
            .pending (pending[i]),
            .ready   (ready_v[i]),
            .dout    (dout_v[i])
        );
    end

    assign p0_dout  = dout_v[0];
    assign p1_dout  = dout_v[1];
    assign p2_dout  = dout_v[2];
    assign p0_ready = ready_v[0];
    assign p1_ready = ready_v[1];
    assign p2_ready = ready_v[2];

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [1:0]    grant;
    logic [1:0]    grant_nxt;
    logic [1:0]    last;
    logic [1:0]    last_nxt;
    logic [1:0]    pick;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] din_nxt;
    logic [1:0]    wtbt_nxt;
    logic          rd_nxt;
    logic          we_nxt;

    assign pick = rr_pick(pending, last, PRIO0);

    always_ff @(posedge clk) begin
        if (init) begin
            state   <= IDLE;
            grant   <= 2'd0;
            last    <= 2'd2;
            sd_addr <= '0;
            sd_din  <= '0;
            sd_wtbt <= '0;
            sd_rd   <= 1'b0;
            sd_we   <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            last    <= last_nxt;
            sd_addr <= addr_nxt;
            sd_din  <= din_nxt;
            sd_wtbt <= wtbt_nxt;
            sd_rd   <= rd_nxt;
            sd_we   <= we_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        addr_nxt  = sd_addr;
        din_nxt   = sd_din;
        wtbt_nxt  = sd_wtbt;
        rd_nxt    = sd_rd;
        we_nxt    = sd_we;
        done_v    = '0;
        load_v    = '0;
        case (state)
            IDLE: begin
                if (sd_ready && (|pending)) begin
                    grant_nxt = pick;
                    // Priority grants to port 0 leave the 1/2 rotation where it was.
                    if (!(PRIO0 && pick == 2'd0)) begin
                        last_nxt = pick;
                    end
                    addr_nxt  = req_v[pick].addr;
                    din_nxt   = req_v[pick].din;
                    wtbt_nxt  = req_v[pick].wtbt;
                    we_nxt    = req_v[pick].op;
                    rd_nxt    = ~req_v[pick].op;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = GUARD;
            GUARD: state_nxt = WAIT;
            WAIT: begin
                if (sd_ready) begin
                    load_v[grant] = ~req_v[grant].op;
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                rd_nxt        = 1'b0;
                we_nxt        = 1'b0;
                done_v[grant] = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench: two arbiters (round-robin and port-0 priority) share stimulus,
// each with its own behavioural controller model.
module tb_sdram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        init;
    logic        rd [3];
    logic        we [3];
    logic [24:0] addr_i [3];
    logic [15:0] din_i [3];
    logic [1:0]  wtbt_i [3];
    logic [15:0] dout [2][3];
    logic        ready [2][3];
    logic [24:0] sd_addr [2];
    logic [15:0] sd_din [2];
    logic [15:0] sd_dout [2];
    logic [1:0]  sd_wtbt [2];
    logic        sd_rd [2];
    logic        sd_we [2];
    logic        sd_ready [2];

    sdram_arbiter #(.PRIO0(1'b0)) u_rr (
        .clk(clk), .init(init),
        .p0_rd(rd[0]), .p0_we(we[0]), .p0_addr(addr_i[0]), .p0_din(din_i[0]), .p0_wtbt(wtbt_i[0]),
        .p0_dout(dout[0][0]), .p0_ready(ready[0][0]),
        .p1_rd(rd[1]), .p1_we(we[1]), .p1_addr(addr_i[1]), .p1_din(din_i[1]), .p1_wtbt(wtbt_i[1]),
        .p1_dout(dout[0][1]), .p1_ready(ready[0][1]),
        .p2_rd(rd[2]), .p2_we(we[2]), .p2_addr(addr_i[2]), .p2_din(din_i[2]), .p2_wtbt(wtbt_i[2]),
        .p2_dout(dout[0][2]), .p2_ready(ready[0][2]),
        .sd_addr(sd_addr[0]), .sd_din(sd_din[0]), .sd_wtbt(sd_wtbt[0]),
        .sd_rd(sd_rd[0]), .sd_we(sd_we[0]), .sd_dout(sd_dout[0]), .sd_ready(sd_ready[0])
    );

    sdram_arbiter #(.PRIO0(1'b1)) u_pr (
        .clk(clk), .init(init),
        .p0_rd(rd[0]), .p0_we(we[0]), .p0_addr(addr_i[0]), .p0_din(din_i[0]), .p0_wtbt(wtbt_i[0]),
        .p0_dout(dout[1][0]), .p0_ready(ready[1][0]),
        .p1_rd(rd[1]), .p1_we(we[1]), .p1_addr(addr_i[1]), .p1_din(din_i[1]), .p1_wtbt(wtbt_i[1]),
        .p1_dout(dout[1][1]), .p1_ready(ready[1][1]),
        .p2_rd(rd[2]), .p2_we(we[2]), .p2_addr(addr_i[2]), .p2_din(din_i[2]), .p2_wtbt(wtbt_i[2]),
        .p2_dout(dout[1][2]), .p2_ready(ready[1][2]),
        .sd_addr(sd_addr[1]), .sd_din(sd_din[1]), .sd_wtbt(sd_wtbt[1]),
        .sd_rd(sd_rd[1]), .sd_we(sd_we[1]), .sd_dout(sd_dout[1]), .sd_ready(sd_ready[1])
    );

    // Controller model: a miss or write drops ready for 3 cycles; a read of the
    // latched word keeps ready high. Odd byte addresses return the word byte-swapped.
    logic [15:0] mem [2][256];
    int          cnt [2];
    logic        lat_v [2];
    logic [23:0] lat_w [2];
    logic        prev_rd [2];
    logic        prev_we [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            prev_rd[k] <= sd_rd[k];
            prev_we[k] <= sd_we[k];
            if (init) begin
                sd_ready[k] <= 1'b1;
                cnt[k]      <= 0;
                lat_v[k]    <= 1'b0;
            end else begin
                if (cnt[k] != 0) begin
                    cnt[k] <= cnt[k] - 1;
                    if (cnt[k] == 1) sd_ready[k] <= 1'b1;
                end
                if (sd_we[k] && !prev_we[k]) begin
                    if (sd_wtbt[k][1]) mem[k][sd_addr[k][8:1]][15:8] <= sd_din[k][15:8];
                    if (sd_wtbt[k][0]) mem[k][sd_addr[k][8:1]][7:0]  <= sd_din[k][7:0];
                    sd_ready[k] <= 1'b0;
                    cnt[k]      <= 3;
                    lat_v[k]    <= 1'b0;
                end else if (sd_rd[k] && !prev_rd[k]) begin
                    sd_dout[k] <= sd_addr[k][0] ?
                                  {mem[k][sd_addr[k][8:1]][7:0], mem[k][sd_addr[k][8:1]][15:8]} :
                                  mem[k][sd_addr[k][8:1]];
                    if (!(lat_v[k] && lat_w[k] == sd_addr[k][24:1])) begin
                        sd_ready[k] <= 1'b0;
                        cnt[k]      <= 3;
                        lat_v[k]    <= 1'b1;
                        lat_w[k]    <= sd_addr[k][24:1];
                    end
                end
            end
        end
    end

    // Log every controller request (rising sd_rd/sd_we) in issue order.
    logic [24:0] qa0 [$];
    logic [24:0] qa1 [$];
    logic        qw0 [$];
    logic        qw1 [$];
    logic        mprev [2];

    always @(negedge clk) begin
        if ((sd_rd[0] || sd_we[0]) && !mprev[0]) begin
            qa0.push_back(sd_addr[0]);
            qw0.push_back(sd_we[0]);
        end
        if ((sd_rd[1] || sd_we[1]) && !mprev[1]) begin
            qa1.push_back(sd_addr[1]);
            qw1.push_back(sd_we[1]);
        end
        mprev[0] <= sd_rd[0] || sd_we[0];
        mprev[1] <= sd_rd[1] || sd_we[1];
    end

    function automatic logic [24:0] qa_at(input int k, input int i);
        if (k == 0) return (i < qa0.size()) ? qa0[i] : 25'h1FFFFFF;
        return (i < qa1.size()) ? qa1[i] : 25'h1FFFFFF;
    endfunction

    function automatic logic [1:0] qw_at(input int k, input int i);
        if (k == 0) return (i < qw0.size()) ? {1'b0, qw0[i]} : 2'b11;
        return (i < qw1.size()) ? {1'b0, qw1[i]} : 2'b11;
    endfunction

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic all_idle();
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (sd_rd[k] || sd_we[k]) ok = 1'b0;
            for (int p = 0; p < 3; p++) if (!ready[k][p]) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while (!all_idle() && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk(name, 32'(cyc < 200), 32'd1);
    endtask

    task automatic init_pulse();
        @(negedge clk);
        init = 1'b1;
        repeat (2) @(negedge clk);
        init = 1'b0;
    endtask

    typedef struct {
        int          port;
        logic        wr;
        logic [24:0] addr;
        logic [15:0] din;
        logic [15:0] exp_dout;
        int          exp_low;
    } vec_t;

    // One transaction on the priority instance: low = cycles ready stays low.
    task automatic run_vec(input int idx, input vec_t v);
        int          base;
        int          low;
        logic [15:0] old;
        base = qa1.size();
        old  = dout[1][v.port];
        @(negedge clk);
        addr_i[v.port] = v.addr;
        din_i[v.port]  = v.din;
        wtbt_i[v.port] = 2'b11;
        if (v.wr) we[v.port] = 1'b1;
        else      rd[v.port] = 1'b1;
        @(negedge clk);
        we[v.port] = 1'b0;
        rd[v.port] = 1'b0;
        low = 0;
        while (!ready[1][v.port] && low < 60) begin
            low++;
            @(negedge clk);
        end
        chk($sformatf("v%0d_low", idx), 32'(low), 32'(v.exp_low));
        chk($sformatf("v%0d_nreq", idx), 32'(qa1.size() - base), 32'd1);
        chk($sformatf("v%0d_addr", idx), 32'(qa_at(1, base)), 32'(v.addr));
        chk($sformatf("v%0d_op", idx), 32'(qw_at(1, base)), 32'(v.wr));
        chk($sformatf("v%0d_dout", idx), 32'(dout[1][v.port]), 32'(v.wr ? old : v.exp_dout));
    endtask

    vec_t vecs [11];
    int   b0;
    int   b1;
    int   cyc;

    initial begin
        vecs[0]  = '{1, 1'b1, 25'h000100, 16'hA5A5, 16'h0000, 7};
        vecs[1]  = '{1, 1'b0, 25'h000100, 16'h0000, 16'hA5A5, 7};
        vecs[2]  = '{0, 1'b1, 25'h000200, 16'h1234, 16'h0000, 7};
        vecs[3]  = '{2, 1'b0, 25'h000200, 16'h0000, 16'h1234, 7};
        vecs[4]  = '{2, 1'b0, 25'h000201, 16'h0000, 16'h3412, 5};
        vecs[5]  = '{0, 1'b1, 25'h000010, 16'h5AC3, 16'h0000, 7};
        vecs[6]  = '{2, 1'b0, 25'h000010, 16'h0000, 16'h5AC3, 7};
        vecs[7]  = '{2, 1'b0, 25'h000011, 16'h0000, 16'hC35A, 5};
        vecs[8]  = '{0, 1'b1, 25'h000300, 16'hBEEF, 16'h0000, 7};
        vecs[9]  = '{0, 1'b0, 25'h000301, 16'h0000, 16'hEFBE, 7};
        vecs[10] = '{1, 1'b0, 25'h000300, 16'h0000, 16'hBEEF, 5};

        init = 1'b1;
        for (int p = 0; p < 3; p++) begin
            rd[p] = 1'b0; we[p] = 1'b0;
            addr_i[p] = '0; din_i[p] = '0; wtbt_i[p] = '0;
        end
        repeat (3) @(negedge clk);
        init = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_ready%0d", k), 32'({ready[k][2], ready[k][1], ready[k][0]}), 32'h7);
            chk($sformatf("rst_dout%0d", k), 32'(dout[k][0] | dout[k][1] | dout[k][2]), 32'h0);
            chk($sformatf("rst_sdreq%0d", k), 32'({sd_rd[k], sd_we[k]}), 32'h0);
            chk($sformatf("rst_sdaddr%0d", k), 32'(sd_addr[k]), 32'h0);
        end

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Three simultaneous reads, twice: pure round-robin serves 0,1,2 each time.
        init_pulse();
        b0 = qa0.size();
        for (int rep = 0; rep < 2; rep++) begin
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                addr_i[p] = 25'h400 + 25'(2 * p);
                rd[p] = 1'b1;
            end
            @(negedge clk);
            for (int p = 0; p < 3; p++) rd[p] = 1'b0;
            wait_idle($sformatf("A%0d_idle", rep));
            for (int p = 0; p < 3; p++)
                chk($sformatf("A%0d_order%0d", rep, p), 32'(qa_at(0, b0 + 3 * rep + p)),
                    32'h400 + 32'(2 * p));
        end

        // p1/p2 pending, p0 arrives while p1 is in service.
        init_pulse();
        b0 = qa0.size();
        b1 = qa1.size();
        @(negedge clk);
        addr_i[1] = 25'h402; addr_i[2] = 25'h404;
        rd[1] = 1'b1; rd[2] = 1'b1;
        @(negedge clk);
        rd[1] = 1'b0; rd[2] = 1'b0;
        cyc = 0;
        while (qa1.size() == b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        addr_i[0] = 25'h400;
        rd[0] = 1'b1;
        @(negedge clk);
        rd[0] = 1'b0;
        wait_idle("B_idle");
        chk("B_pr_order0", 32'(qa_at(1, b1)),     32'h402);
        chk("B_pr_order1", 32'(qa_at(1, b1 + 1)), 32'h400);
        chk("B_pr_order2", 32'(qa_at(1, b1 + 2)), 32'h404);
        chk("B_rr_order0", 32'(qa_at(0, b0)),     32'h402);
        chk("B_rr_order1", 32'(qa_at(0, b0 + 1)), 32'h404);
        chk("B_rr_order2", 32'(qa_at(0, b0 + 2)), 32'h400);

        // init in WAIT, with p2_we raised during init and held afterwards.
        init_pulse();
        run_vec(11, '{1, 1'b0, 25'h000300, 16'h0000, 16'hBEEF, 7});
        b1 = qa1.size();
        @(negedge clk);
        addr_i[1] = 25'h500;
        rd[1] = 1'b1;
        @(negedge clk);
        rd[1] = 1'b0;
        cyc = 0;
        while (qa1.size() == b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        init = 1'b1;
        addr_i[2] = 25'h600;
        we[2] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("D_ready%0d", k), 32'({ready[k][2], ready[k][1], ready[k][0]}), 32'h7);
            chk($sformatf("D_sdreq%0d", k), 32'({sd_rd[k], sd_we[k]}), 32'h0);
        end
        chk("D_dout", 32'(dout[1][1]), 32'h0);
        init = 1'b0;
        b1 = qa1.size();
        repeat (10) @(negedge clk);
        chk("D_noreq", 32'(qa1.size() - b1), 32'h0);
        chk("D_p2ready", 32'(ready[1][2]), 32'h1);
        we[2] = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
